ziposoc_data_bus: RTL and testbench
===================================

// Module: ziposoc_data_bus
// PURPOSE
//  Single-port system data bus between the zipocpu core and its address space.
//  Decodes a 64-bit word address into on-chip RAM, an 8-bit LED register and an unmapped region.
//  Completes one read or write per clock and flags out-of-range accesses on exception.
//  The CPU sweeps addresses and the SoC bench stops when addr reaches MEM_END.
// PARAMETERS
//  ADDR_W    64   address width; addresses are word indices, not byte addresses
//  DATA_W    64   data word width
//  MEM_WORDS 256  RAM depth in DATA_W words; must be a power of two
// PORTS
//  clk        in   1       single system clock; all logic on its rising edge
//  rst_n      in   1       synchronous reset, active-low, sampled on the rising edge of clk
//  rw         in   1       access type: 1 = write, 0 = read; one access every cycle
//  addr       in   ADDR_W  word address of the current access
//  write      in   DATA_W  write data, used when rw = 1
//  read       out  DATA_W  registered read data
//  exception  out  1       registered out-of-range flag for the previous access
//  led        out  8       LED register contents
// BEHAVIOUR
//  Memory map, defined in memory_map.v:
//   MEM_START = 0
//   RAM:      MEM_START .. MEM_WORDS-1
//   LED_ADDR  = MEM_WORDS
//   MEM_END   = MEM_WORDS+1; first unmapped address
//  Reset, when rst_n = 0 at a clk edge:
//   read <= 0, exception <= 0, led <= 0
//   RAM contents are not reset; RAM is zero-initialised at power-up/simulation start
//   Reset has priority over any access in the same cycle; that access is discarded
//  Read (rw = 0), 1-cycle latency:
//   RAM hit: read <= mem[addr]
//   addr == LED_ADDR: read <= {56'b0, led}
//   addr >= MEM_END: read <= 0, exception <= 1
//  Write (rw = 1):
//   RAM hit: mem[addr] <= write
//   addr == LED_ADDR: led <= write[7:0]
//   addr >= MEM_END: write dropped, exception <= 1
//   read holds its previous value on write cycles
//  exception is not sticky: each in-range access cycle clears it to 0.
//  A read of an address written in the immediately preceding cycle returns the new data.
//  Addresses are compared at the full ADDR_W width:
//   no aliasing or wrap-around; any upper bit set means unmapped
//  No wait states, no handshake: the bus always accepts.
// STRUCTURE
//  memory_map.v (shared include): MEM_START, MEM_WORDS, LED_ADDR, MEM_END.
//   The CPU and the SoC bench use the same definitions.
//  Sub-module ziposoc_ram: single-port synchronous RAM (we, addr, wdata, rdata).
//   Read-after-write returns new data.
//  Top level contains the address decoder, LED register, read mux and exception register.
// TESTING
//  1. Reset: hold rst_n = 0 for 2 clocks -> read = 0, exception = 0, led = 0.
//  2. RAM round trip:
//     write 64'hDEADBEEF_01234567 to addr 5, then read addr 5
//     -> read = 64'hDEADBEEF_01234567 one cycle later, exception = 0.
//  3. LED:
//     write 64'hFF_B6 to LED_ADDR -> led = 8'hB6
//     read LED_ADDR -> read = 64'h0000_0000_0000_00B6.
//  4. Out-of-range read at MEM_END -> read = 0, exception = 1 for one cycle.
//     Out-of-range write at 64'h8000_0000_0000_0000 -> exception = 1; RAM and led unchanged.
//  5. Boundary:
//     write/read addr MEM_WORDS-1 -> data returned
//     next cycle with an in-range access -> exception = 0.
//  6. Reset mid-operation:
//     assert rst_n = 0 in the same cycle as a write to the LED
//     -> led = 0 and the write is lost; previously written RAM data survives.

Source files
------------

// File: rtl/ziposoc_data_bus_pkg.sv
// Shared memory-map definitions and the address-region type for the zipocpu SoC data bus.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

package ziposoc_data_bus_pkg;

  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 64;
  localparam int MEM_WORDS_DEF = 256;

  localparam longint unsigned MEM_START = 64'd0;

  typedef enum logic [1:0] {
    RGN_RAM      = 2'd0,
    RGN_LED      = 2'd1,
    RGN_UNMAPPED = 2'd2
  } region_e;

  // LED register sits directly above RAM; the first unmapped word follows it.
  function automatic longint unsigned led_addr(input longint unsigned mem_words);
    return mem_words;
  endfunction

  function automatic longint unsigned mem_end(input longint unsigned mem_words);
    return mem_words + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ziposoc_ram.sv
// Single-port synchronous RAM; a read issued the cycle after a write returns the new data.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module ziposoc_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on read cycles so the bus can hold its last read value.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/ziposoc_data_bus.sv
// System data bus: decodes word addresses into RAM, the LED register and unmapped space.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module ziposoc_data_bus
  import ziposoc_data_bus_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write,
  output logic [DATA_W-1:0] read,
  output logic              exception,
  output logic [7:0]        led
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(led_addr(MEM_WORDS));

  region_e           region;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] read_hold;
  logic              read_from_ram;

  // Full-width compares: any set upper bit lands in the unmapped region.
  always_comb begin
    region = RGN_UNMAPPED;
    if (addr < LED_ADDR)       region = RGN_RAM;
    else if (addr == LED_ADDR) region = RGN_LED;
  end

  assign ram_we = rst_n &&  rw && (region == RGN_RAM);
  assign ram_re = rst_n && !rw && (region == RGN_RAM);

  ziposoc_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_WORDS),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr[IDX_W-1:0]),
    .wdata (write),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_hold     <= '0;
      read_from_ram <= 1'b0;
      exception     <= 1'b0;
      led           <= 8'h00;
    end else begin
      exception <= (region == RGN_UNMAPPED);
      if (rw) begin
        if (region == RGN_LED) led <= write[7:0];
      end else begin
        unique case (region)
          RGN_RAM: read_from_ram <= 1'b1;
          RGN_LED: begin
            read_hold     <= DATA_W'(led);
            read_from_ram <= 1'b0;
          end
          default: begin
            read_hold     <= '0;
            read_from_ram <= 1'b0;
          end
        endcase
      end
    end
  end

  // Write cycles leave both sources untouched, so read holds its value.
  assign read = read_from_ram ? ram_rdata : read_hold;

endmodule

`default_nettype wire

// File: tb/tb_ziposoc_data_bus.sv
// Scoreboard bench for ziposoc_data_bus using directed, hand-computed vectors.
`timescale 1ns/1ps
`default_nettype none

module tb_ziposoc_data_bus;

  localparam logic [63:0] LED_A   = 64'd256;
  localparam logic [63:0] MEND_A  = 64'd257;
  localparam logic [63:0] TOP_RAM = 64'd255;
  localparam logic [63:0] PAT_A   = 64'hDEADBEEF_01234567;
  localparam logic [63:0] PAT_B   = 64'h11223344_55667788;
  localparam logic [63:0] PAT_C   = 64'hAAAA5555_AAAA5555;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rw    = 1'b0;
  logic [63:0] addr  = '0;
  logic [63:0] write = '0;
  logic [63:0] read;
  logic        exception;
  logic [7:0]  led;

  typedef struct {
    logic [63:0] rd;
    logic        exc;
    logic [7:0]  led;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   vec_id     = 0;

  ziposoc_data_bus dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rw        (rw),
    .addr      (addr),
    .write     (write),
    .read      (read),
    .exception (exception),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Drive one access at the falling edge; the expectation applies after the next rising edge.
  task automatic step(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] er, input logic ee, input logic [7:0] el);
    @(negedge clk);
    rst_n = r;
    rw    = w;
    addr  = a;
    write = d;
    vec_id++;
    sb.push_back('{rd: er, exc: ee, led: el, id: vec_id});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("read", e.id, read, e.rd);
        chk("exception", e.id, {63'd0, exception}, {63'd0, e.exc});
        chk("led", e.id, {56'd0, led}, {56'd0, e.led});
      end
    end
  end

  initial begin : stimulus
    bit drained;
    //    rst_n rw    addr                    write          read    exc   led
    step(1'b0, 1'b0, 64'd0,                  64'd0,         64'd0,  1'b0, 8'h00);
    step(1'b0, 1'b0, 64'd0,                  64'd0,         64'd0,  1'b0, 8'h00);
    step(1'b1, 1'b1, 64'd5,                  PAT_A,         64'd0,  1'b0, 8'h00);
    step(1'b1, 1'b0, 64'd5,                  64'd0,         PAT_A,  1'b0, 8'h00);
    step(1'b1, 1'b1, LED_A,                  64'hFF_B6,     PAT_A,  1'b0, 8'hB6);
    step(1'b1, 1'b0, LED_A,                  64'd0,         64'hB6, 1'b0, 8'hB6);
    step(1'b1, 1'b0, MEND_A,                 64'd0,         64'd0,  1'b1, 8'hB6);
    step(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h77,       64'd0,  1'b1, 8'hB6);
    step(1'b1, 1'b0, 64'd5,                  64'd0,         PAT_A,  1'b0, 8'hB6);
    step(1'b1, 1'b1, TOP_RAM,                PAT_B,         PAT_A,  1'b0, 8'hB6);
    step(1'b1, 1'b0, TOP_RAM,                64'd0,         PAT_B,  1'b0, 8'hB6);
    step(1'b1, 1'b0, MEND_A,                 64'd0,         64'd0,  1'b1, 8'hB6);
    step(1'b1, 1'b0, TOP_RAM,                64'd0,         PAT_B,  1'b0, 8'hB6);
    step(1'b1, 1'b0, 64'h1_0000_0005,        64'd0,         64'd0,  1'b1, 8'hB6);
    step(1'b1, 1'b1, 64'd0,                  PAT_C,         64'd0,  1'b0, 8'hB6);
    step(1'b1, 1'b0, 64'd0,                  64'd0,         PAT_C,  1'b0, 8'hB6);
    step(1'b1, 1'b0, 64'd5,                  64'd0,         PAT_A,  1'b0, 8'hB6);
    step(1'b0, 1'b1, LED_A,                  64'h3C,        64'd0,  1'b0, 8'h00);
    step(1'b1, 1'b0, LED_A,                  64'd0,         64'd0,  1'b0, 8'h00);
    step(1'b1, 1'b0, 64'd5,                  64'd0,         PAT_A,  1'b0, 8'h00);
    step(1'b1, 1'b0, TOP_RAM,                64'd0,         PAT_B,  1'b0, 8'h00);

    drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
